sinewave_period_meter: RTL

Receive-side counterpart to the DDS sine source: consumes the offset-binary sample stream at the sample-clock enable rate, detects rising zero crossings with hysteresis, and measures the average period in samples over a window of several cycles, together with the peak and trough of that window. It sits on the loopback/self-test path between the sine source (or ADC capture) and the control/status registers. It provides on-chip verification of programmed phase increments and DAC-path tone frequency.

---
 rtl/sinewave_period_meter_pkg.sv | 21 ++
 rtl/sinewave_period_meter_zc_detector.sv | 48 ++++
 rtl/sinewave_period_meter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sinewave_period_meter_pkg.sv
// Shared definitions for the sine period meter and its register-map block.
//   meter_state_t : measurement FSM states
//   midscale()    : offset-binary midscale code for a given sample width
//   period_shift(): right shift that divides a window total by PERIODS
`timescale 1ns/1ps
package sinewave_period_meter_pkg;

    typedef enum logic {
        ACQUIRE = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

    function automatic int unsigned midscale(input int unsigned data_width);
        return 32'd1 << (data_width - 1);
    endfunction

    function automatic int unsigned period_shift(input int unsigned periods);
        return $clog2(periods);
    endfunction

endpackage

// File: rtl/sinewave_period_meter_zc_detector.sv
// Rising zero-crossing detector with hysteresis around midscale.
//   clk, arst      : clock, asynchronous active-high reset
//   sample_clk_ce  : sample strobe; polarity only moves on strobe cycles
//   sinewave       : offset-binary input sample
//   rise           : combinational pulse, high on the strobe cycle whose
//                    sample moves the polarity from low to high
`timescale 1ns/1ps
module sinewave_zc_detector
    import sinewave_period_meter_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int HYST       = 256
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  sample_clk_ce,
    input  logic [DATA_WIDTH-1:0] sinewave,
    output logic                  rise
);

    localparam logic [DATA_WIDTH-1:0] HI_TH = DATA_WIDTH'(midscale(DATA_WIDTH) + HYST);
    localparam logic [DATA_WIDTH-1:0] LO_TH = DATA_WIDTH'(midscale(DATA_WIDTH) - HYST);

    logic polarity;
    logic above;
    logic below;

    assign above = (sinewave >= HI_TH);
    assign below = (sinewave < LO_TH);

    // Polarity starts high so a tone must be seen low before its first rise.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            polarity <= 1'b1;
        end else if (sample_clk_ce) begin
            if (above) begin
                polarity <= 1'b1;
            end else if (below) begin
                polarity <= 1'b0;
            end
        end
    end

    // Issued in the same cycle as the crossing sample so the FSM can seed
    // the next window with that sample.
    assign rise = sample_clk_ce & above & ~polarity;

endmodule

// File: rtl/sinewave_period_meter.sv
// Measures the average period (in samples) of a sampled sine over PERIODS
// rising crossings, plus the peak and trough seen in that window.
//   clk, arst      : clock, asynchronous active-high reset
//   sample_clk_ce  : sample strobe; nothing changes on cycles it is low
//   sinewave       : offset-binary sample
//   period         : window total >> log2(PERIODS)
//   peak, trough   : max / min sample of the last window
//   meas_valid     : one-clk pulse when period/peak/trough refresh
//   timeout        : sticky, no crossing within 2^COUNT_WIDTH-1 samples
//
//   state   | meaning
//   ACQUIRE | waiting for a rising crossing to open the first window
//   MEASURE | counting samples and crossings, windows back-to-back
`timescale 1ns/1ps
module sinewave_period_meter
    import sinewave_period_meter_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int HYST        = 256,
    parameter int PERIODS     = 4,
    parameter int COUNT_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   sample_clk_ce,
    input  logic [DATA_WIDTH-1:0]  sinewave,
    output logic [COUNT_WIDTH-1:0] period,
    output logic [DATA_WIDTH-1:0]  peak,
    output logic [DATA_WIDTH-1:0]  trough,
    output logic                   meas_valid,
    output logic                   timeout
);

    localparam int SHIFT  = period_shift(PERIODS);
    localparam int RISE_W = (PERIODS > 1) ? $clog2(PERIODS) : 1;
    localparam logic [RISE_W-1:0]      LAST_RISE = RISE_W'(PERIODS - 1);
    // One below saturation: the next non-crossing sample hits the limit.
    localparam logic [COUNT_WIDTH-1:0] CNT_LAST  = {{(COUNT_WIDTH-1){1'b1}}, 1'b0};

    meter_state_t           state;
    logic                   rise;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0] acc;
    logic [COUNT_WIDTH-1:0] total;
    logic [RISE_W-1:0]      rise_cnt;
    logic [DATA_WIDTH-1:0]  run_max;
    logic [DATA_WIDTH-1:0]  run_min;
    logic [DATA_WIDTH-1:0]  win_max;
    logic [DATA_WIDTH-1:0]  win_min;

    sinewave_zc_detector #(
        .DATA_WIDTH (DATA_WIDTH),
        .HYST       (HYST)
    ) u_zc (
        .clk           (clk),
        .arst          (arst),
        .sample_clk_ce (sample_clk_ce),
        .sinewave      (sinewave),
        .rise          (rise)
    );

    // cnt holds samples since the last crossing (exclusive); acc holds the
    // completed periods of the window, so total includes the current sample.
    assign total   = acc + cnt + COUNT_WIDTH'(1);
    assign win_max = (sinewave > run_max) ? sinewave : run_max;
    assign win_min = (sinewave < run_min) ? sinewave : run_min;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= ACQUIRE;
            cnt        <= '0;
            acc        <= '0;
            rise_cnt   <= '0;
            run_max    <= '0;
            run_min    <= '1;
            period     <= '0;
            peak       <= '0;
            trough     <= '1;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (sample_clk_ce) begin
                case (state)
                    ACQUIRE: begin
                        if (rise) begin
                            state    <= MEASURE;
                            cnt      <= '0;
                            acc      <= '0;
                            rise_cnt <= '0;
                            run_max  <= sinewave;
                            run_min  <= sinewave;
                        end
                    end
                    MEASURE: begin
                        // A crossing takes priority over counter saturation.
                        if (rise) begin
                            cnt <= '0;
                            if (rise_cnt == LAST_RISE) begin
                                period     <= total >> SHIFT;
                                peak       <= win_max;
                                trough     <= win_min;
                                meas_valid <= 1'b1;
                                timeout    <= 1'b0;
                                acc        <= '0;
                                rise_cnt   <= '0;
                                run_max    <= sinewave;
                                run_min    <= sinewave;
                            end else begin
                                acc      <= total;
                                rise_cnt <= rise_cnt + 1'b1;
                                run_max  <= win_max;
                                run_min  <= win_min;
                            end
                        end else if (cnt == CNT_LAST) begin
                            cnt     <= cnt + 1'b1;
                            timeout <= 1'b1;
                            state   <= ACQUIRE;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            run_max <= win_max;
                            run_min <= win_min;
                        end
                    end
                    default: state <= ACQUIRE;
                endcase
            end
        end
    end

endmodule
